// File: rtl/trig_time_readout.sv
// -----------------------------------------------------------------------------
// trig_time_readout
//
// Counts accepted triggers and, for each one, emits a two-word event to the
// event builder: a header word carrying the running event number, then a data
// word carrying the trigger-time byte fetched from the trigger time FIFO. If
// the FIFO stays empty for TIMEOUT_CYC cycles, the event is closed with the
// timeout bit set and a zero time byte.
//
// State   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a pending trigger while enabled
// HDR     | header word offered on DATA_OUT
// RD      | waiting for FIFO data; issues the single FIFO_RD strobe
// CAP     | FIFO_Q registered as the trigger time
// DAT     | data word offered on DATA_OUT
//
// Ports
//   CLK           sole clock, rising edge
//   RST           synchronous active-high reset
//   ENABLE        permits trigger counting and event start
//   TRIG          one-cycle trigger pulse
//   FIFO_Q        trigger-time byte, valid the cycle after FIFO_RD
//   FIFO_EMPTY    trigger time FIFO empty
//   FIFO_FULL     trigger time FIFO full (latched into the header)
//   FIFO_RD       one-cycle FIFO read strobe
//   DATA_OUT      event word
//   DATA_VALID    DATA_OUT valid
//   DATA_READY    event builder accepts the word
//   EVENT_DONE    one-cycle pulse on data-word transfer
//   PENDING       triggers counted but not yet read out
//   OVERFLOW_ERR  sticky: trigger lost with PENDING saturated
//   TIMEOUT_ERR   sticky: an event closed by timeout
//   ERR_CLEAR     clears both sticky flags (a coincident set wins)
// -----------------------------------------------------------------------------
module trig_time_readout #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ENABLE,
    input  logic        TRIG,
    input  logic [7:0]  FIFO_Q,
    input  logic        FIFO_EMPTY,
    input  logic        FIFO_FULL,
    output logic        FIFO_RD,
    output logic [31:0] DATA_OUT,
    output logic        DATA_VALID,
    input  logic        DATA_READY,
    output logic        EVENT_DONE,
    output logic [3:0]  PENDING,
    output logic        OVERFLOW_ERR,
    output logic        TIMEOUT_ERR,
    input  logic        ERR_CLEAR
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        RD   = 3'd2,
        CAP  = 3'd3,
        DAT  = 3'd4
    } state_t;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  pending;
    logic [23:0] evt_cnt;
    logic [15:0] timer;
    logic [7:0]  trig_time;
    logic        tmo;
    logic        full_lat;
    logic        overflow_err;
    logic        timeout_err;

    logic        hdr_xfer;
    logic        dat_xfer;
    logic        tmo_hit;
    logic        trig_acc;
    logic        ovf_set;

    assign trig_acc = TRIG && ENABLE;
    // A trigger arriving on the data-word transfer cancels the decrement, so
    // it never counts as an overflow even when PENDING sits at 15.
    assign ovf_set  = trig_acc && !dat_xfer && (pending == 4'hF);

    // ------------------------------------------------------------------
    // Next-state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        FIFO_RD    = 1'b0;
        DATA_VALID = 1'b0;
        DATA_OUT   = 32'h0000_0000;
        EVENT_DONE = 1'b0;
        hdr_xfer   = 1'b0;
        dat_xfer   = 1'b0;
        tmo_hit    = 1'b0;

        case (state)
            IDLE: begin
                if ((pending != 4'd0) && ENABLE) begin
                    state_nxt = HDR;
                end
            end
            HDR: begin
                DATA_VALID = 1'b1;
                DATA_OUT   = {4'hA, 3'b000, full_lat, evt_cnt};
                if (DATA_READY) begin
                    hdr_xfer  = 1'b1;
                    state_nxt = RD;
                end
            end
            RD: begin
                if (!FIFO_EMPTY) begin
                    FIFO_RD   = 1'b1;
                    state_nxt = CAP;
                end else if (timer == TIMER_LAST) begin
                    tmo_hit   = 1'b1;
                    state_nxt = DAT;
                end
            end
            CAP: begin
                state_nxt = DAT;
            end
            DAT: begin
                DATA_VALID = 1'b1;
                DATA_OUT   = {4'hB, 3'b000, tmo, 16'h0000, trig_time};
                if (DATA_READY) begin
                    dat_xfer   = 1'b1;
                    EVENT_DONE = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FIFO_FULL is captured once when the event opens so the header stays
    // stable however long the event builder stalls.
    always_ff @(posedge CLK) begin
        if (RST) begin
            full_lat <= 1'b0;
        end else if ((state == IDLE) && (state_nxt == HDR)) begin
            full_lat <= FIFO_FULL;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            timer <= 16'd0;
        end else if (hdr_xfer) begin
            timer <= 16'd0;
        end else if ((state == RD) && FIFO_EMPTY && !tmo_hit) begin
            timer <= timer + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            trig_time <= 8'h00;
            tmo       <= 1'b0;
        end else if (state == CAP) begin
            trig_time <= FIFO_Q;
            tmo       <= 1'b0;
        end else if (tmo_hit) begin
            trig_time <= 8'h00;
            tmo       <= 1'b1;
        end
    end

    // Wraps from 24'hFFFFFF to 0 by natural overflow.
    always_ff @(posedge CLK) begin
        if (RST) begin
            evt_cnt <= 24'd0;
        end else if (dat_xfer) begin
            evt_cnt <= evt_cnt + 24'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pending <= 4'd0;
        end else if (trig_acc && !dat_xfer && (pending != 4'hF)) begin
            pending <= pending + 4'd1;
        end else if (!trig_acc && dat_xfer) begin
            pending <= pending - 4'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            overflow_err <= 1'b0;
        end else if (ovf_set) begin
            overflow_err <= 1'b1;
        end else if (ERR_CLEAR) begin
            overflow_err <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            timeout_err <= 1'b0;
        end else if (tmo_hit) begin
            timeout_err <= 1'b1;
        end else if (ERR_CLEAR) begin
            timeout_err <= 1'b0;
        end
    end

    assign PENDING      = pending;
    assign OVERFLOW_ERR = overflow_err;
    assign TIMEOUT_ERR  = timeout_err;

endmodule

// File: doc/trig_time_readout.md
TRIG_TIME_READOUT -- requirements
Module: trig_time_readout

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255; FIFO-empty wait, in CLK cycles, before an event is closed without time data (range 1..65535).
REQ-002 CLK  input  1  sole clock; all logic rising-edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 ENABLE  input  1  permits trigger counting and event start.
REQ-005 TRIG  input  1  one-cycle pulse per accepted trigger.
REQ-006 FIFO_Q  input  8  trigger-time byte from the trigger time FIFO (read side); valid the cycle after FIFO_RD.
REQ-007 FIFO_EMPTY  input  1  trigger time FIFO empty.
REQ-008 FIFO_FULL  input  1  trigger time FIFO full.
REQ-009 FIFO_RD  output  1  one-cycle read strobe to the trigger time FIFO.
REQ-010 DATA_OUT  output  32  event word to the event builder.
REQ-011 DATA_VALID  output  1  DATA_OUT valid.
REQ-012 DATA_READY  input  1  event builder accepts word.
REQ-013 EVENT_DONE  output  1  one-cycle pulse on data-word transfer.
REQ-014 PENDING  output  4  triggers counted, not yet read out.
REQ-015 OVERFLOW_ERR  output  1  sticky; trigger lost (pending saturated).
REQ-016 TIMEOUT_ERR  output  1  sticky; an event closed by timeout.
REQ-017 ERR_CLEAR  input  1  clears both sticky flags.

Function
REQ-018 Transfer SHALL occur only on a cycle with DATA_VALID=1 and DATA_READY=1; DATA_OUT SHALL hold stable while DATA_VALID=1 and not transferred.
REQ-019 TRIG with ENABLE=1 SHALL increment PENDING; TRIG with ENABLE=0 SHALL be ignored.
REQ-020 TRIG at PENDING=15 SHALL leave PENDING at 15 and set OVERFLOW_ERR.
REQ-021 TRIG coincident with data-word transfer SHALL leave PENDING unchanged (increment and decrement cancel).
REQ-022 FSM states: IDLE, HDR, RD, CAP, DAT.
REQ-023 IDLE -> HDR when PENDING>0 and ENABLE=1; otherwise stay.
REQ-024 HDR: DATA_VALID=1, DATA_OUT={4'hA, 3'b000, FIFO_FULL latched at HDR entry, EVT_CNT[23:0]}; on transfer -> RD, wait timer cleared.
REQ-025 RD: if FIFO_EMPTY=0, FIFO_RD=1 for exactly one cycle -> CAP; else timer increments; at timer=TIMEOUT_CYC-1 with FIFO still empty -> DAT with TMO=1, TIME=8'h00, TIMEOUT_ERR set.
REQ-026 CAP: FIFO_Q registered as TIME, TMO=0 -> DAT.
REQ-027 DAT: DATA_VALID=1, DATA_OUT={4'hB, 3'b000, TMO, 16'h0000, TIME[7:0]}; on transfer: PENDING decrements, EVT_CNT increments, EVENT_DONE=1 for that cycle, -> IDLE.
REQ-028 EVT_CNT SHALL be 24-bit and wrap 24'hFFFFFF -> 0.
REQ-029 FIFO_RD SHALL never assert outside RD or while FIFO_EMPTY=1.
REQ-030 ENABLE deassert mid-event SHALL not abort; the event completes, no new event starts; PENDING retained.
REQ-031 With DATA_READY held high and FIFO non-empty, an event SHALL take 5 cycles IDLE-to-IDLE (IDLE, HDR, RD, CAP, DAT).
REQ-032 ERR_CLEAR coincident with a setting condition SHALL leave the flag set (set wins).

Reset
REQ-033 RST=1 SHALL force state IDLE, PENDING=0, EVT_CNT=0, timer=0, TIME=0, TMO=0, FIFO_RD=0, DATA_VALID=0, DATA_OUT=0, EVENT_DONE=0, OVERFLOW_ERR=0, TIMEOUT_ERR=0 at the next CLK edge, including mid-event (partial event discarded, no FIFO_RD issued).

Verification
REQ-034 Single trigger, FIFO holds 8'h5C, READY=1 -> words 32'hA000_0000 then 32'hB000_005C, one FIFO_RD, EVENT_DONE once, PENDING 1->0.
REQ-035 TIMEOUT_CYC=4, trigger with FIFO empty -> data word 32'hB100_0000 after 4 RD cycles, TIMEOUT_ERR=1, no FIFO_RD; ERR_CLEAR pulse -> TIMEOUT_ERR=0.
REQ-036 17 TRIG pulses while READY=0 -> PENDING=15, OVERFLOW_ERR=1; DATA_OUT stable 32'hA000_0000 throughout stall.
REQ-037 EVT_CNT preloaded by running 2^24 events (or force) at 24'hFFFFFF -> header 32'hA0FF_FFFF, next header 32'hA000_0000.
REQ-038 RST asserted in CAP -> next cycle all outputs at reset values; following trigger yields header 32'hA000_0000.
REQ-039 TRIG coincident with DAT transfer at PENDING=2 -> PENDING remains 2.
